// File: rtl/ball_engine_pkg.sv
// Shared definitions for the pong ball engine: FSM state encoding and direction codes.
package ball_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/ball_engine_lfsr.sv
// Free-running Fibonacci LFSR; bit 0 picks the vertical direction of each serve.
module ball_engine_lfsr #(
    parameter int NUM_BITS = 4
) (
    input  logic in_clock,
    input  logic in_reset,
    output logic out_bit
);

    logic [NUM_BITS-1:0] lfsr_q;
    logic [NUM_BITS-1:0] lfsr_d;

    // Taps on the two top bits give a maximal-length sequence for 4 bits.
    assign lfsr_d  = {lfsr_q[NUM_BITS-2:0], lfsr_q[NUM_BITS-1] ^ lfsr_q[NUM_BITS-2]};
    assign out_bit = lfsr_q[0];

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            lfsr_q <= NUM_BITS'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: serve countdown, paddle/wall collisions, scoring and game-over FSM.
module ball_engine
    import ball_engine_pkg::*;
#(
    parameter int COORD_W     = 12,
    parameter int H_SIZE      = 10,
    parameter int V_SIZE      = 10,
    parameter int IX          = 320,
    parameter int IY          = 240,
    parameter int BAR_WIDTH   = 20,
    parameter int BAR_LENGTH  = 180,
    parameter int D_WIDTH     = 639,
    parameter int D_HEIGHT    = 470,
    parameter int TOP_MARGIN  = 5,
    parameter int SPEED_INIT  = 2,
    parameter int SPEED_MAX   = 6,
    parameter int SERVE_TICKS = 60,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 5
) (
    input  logic               in_clock,
    input  logic               in_reset,
    input  logic               in_ani_stb,
    input  logic               in_animate,
    input  logic               in_start,
    input  logic [COORD_W-1:0] in_leftbar_top,
    input  logic [COORD_W-1:0] in_rightbar_top,
    output logic [COORD_W-1:0] out_x1,
    output logic [COORD_W-1:0] out_x2,
    output logic [COORD_W-1:0] out_y1,
    output logic [COORD_W-1:0] out_y2,
    output logic [SCORE_W-1:0] out_left_score,
    output logic [SCORE_W-1:0] out_right_score,
    output logic               out_left_point,
    output logic               out_right_point,
    output logic [3:0]         out_speed,
    output logic [2:0]         out_state,
    output logic               out_game_over
);

    // Paddle sums are formed two bits wider so bar_top + length never wraps.
    localparam int WIDE  = COORD_W + 2;
    localparam int CNT_W = (SERVE_TICKS < 2) ? 1 : $clog2(SERVE_TICKS + 1);

    localparam logic [COORD_W-1:0] IX_C     = COORD_W'(IX);
    localparam logic [COORD_W-1:0] IY_C     = COORD_W'(IY);
    localparam logic [COORD_W-1:0] H_C      = COORD_W'(H_SIZE);
    localparam logic [COORD_W-1:0] V_C      = COORD_W'(V_SIZE);
    localparam logic [COORD_W-1:0] LLIM_C   = COORD_W'(BAR_WIDTH);
    localparam logic [COORD_W-1:0] RLIM_C   = COORD_W'(D_WIDTH - BAR_WIDTH);
    localparam logic [COORD_W-1:0] BOT_C    = COORD_W'(D_HEIGHT);
    localparam logic [COORD_W-1:0] TOP_C    = COORD_W'(TOP_MARGIN);
    localparam logic [WIDE-1:0]    LEN_W    = WIDE'(BAR_LENGTH);
    localparam logic [WIDE-1:0]    ZONE1_W  = WIDE'(BAR_LENGTH / 3);
    localparam logic [WIDE-1:0]    ZONE2_W  = WIDE'(2 * BAR_LENGTH / 3);
    localparam logic [3:0]         SPD0_C   = 4'(SPEED_INIT);
    localparam logic [3:0]         SPDMAX_C = 4'(SPEED_MAX);
    localparam logic [CNT_W-1:0]   CNT0_C   = CNT_W'(SERVE_TICKS);
    localparam logic [SCORE_W-1:0] WIN_C    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SMAX_C   = '1;

    state_e             state_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic               x_dir_q, y_dir_q, y_move_q;
    logic [3:0]         speed_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SCORE_W-1:0] left_score_q, right_score_q;
    logic               left_point_q, right_point_q;
    logic               point_right_q;

    logic               tick;
    logic               lfsr_bit;
    logic               chk_left, chk_right, on_bar, hit, miss;
    logic [WIDE-1:0]    bar_top_w, y_w;
    logic               x_dir_d, y_dir_d, y_move_d;
    logic [3:0]         speed_d;
    logic [COORD_W-1:0] step_w, x_d, y_d;
    logic [SCORE_W-1:0] score_sel, score_d;
    logic               won;

    ball_engine_lfsr #(
        .NUM_BITS (4)
    ) u_lfsr (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .out_bit  (lfsr_bit)
    );

    assign tick   = in_ani_stb & in_animate;
    assign out_x1 = x_q - H_C;
    assign out_x2 = x_q + H_C;
    assign out_y1 = y_q - V_C;
    assign out_y2 = y_q + V_C;

    always_comb begin
        chk_left  = (x_dir_q == DIR_LEFT)  && (out_x1 <= LLIM_C);
        chk_right = (x_dir_q == DIR_RIGHT) && (out_x2 >= RLIM_C);
        bar_top_w = chk_left ? WIDE'(in_leftbar_top) : WIDE'(in_rightbar_top);
        y_w       = WIDE'(y_q);
        on_bar    = (WIDE'(out_y2) >= bar_top_w) && (WIDE'(out_y1) <= bar_top_w + LEN_W);
        hit       = (chk_left | chk_right) & on_bar;
        miss      = (chk_left | chk_right) & ~on_bar;

        x_dir_d  = x_dir_q;
        y_dir_d  = y_dir_q;
        y_move_d = y_move_q;
        speed_d  = speed_q;

        if (y_move_q) begin
            if (y_dir_q == DIR_UP && out_y1 <= TOP_C) begin
                y_dir_d = DIR_DOWN;
            end else if (y_dir_q == DIR_DOWN && out_y2 >= BOT_C) begin
                y_dir_d = DIR_UP;
            end
        end

        // The paddle zone is applied after the wall so it wins on y direction.
        if (hit) begin
            x_dir_d = ~x_dir_q;
            speed_d = (speed_q >= SPDMAX_C) ? SPDMAX_C : speed_q + 4'd1;
            if (y_w < bar_top_w + ZONE1_W) begin
                y_dir_d  = DIR_UP;
                y_move_d = 1'b1;
            end else if (y_w > bar_top_w + ZONE2_W) begin
                y_dir_d  = DIR_DOWN;
                y_move_d = 1'b1;
            end else begin
                y_move_d = 1'b0;
            end
        end

        step_w = {{(COORD_W-4){1'b0}}, speed_d};
        x_d    = (x_dir_d == DIR_RIGHT) ? x_q + step_w : x_q - step_w;
        if (!y_move_d) begin
            y_d = y_q;
        end else begin
            y_d = (y_dir_d == DIR_DOWN) ? y_q + step_w : y_q - step_w;
        end

        score_sel = point_right_q ? right_score_q : left_score_q;
        score_d   = (score_sel == SMAX_C) ? score_sel : score_sel + 1'b1;
        won       = (score_d >= WIN_C);
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q       <= ST_IDLE;
            x_q           <= IX_C;
            y_q           <= IY_C;
            x_dir_q       <= DIR_RIGHT;
            y_dir_q       <= DIR_DOWN;
            y_move_q      <= 1'b1;
            speed_q       <= SPD0_C;
            cnt_q         <= '0;
            left_score_q  <= '0;
            right_score_q <= '0;
            left_point_q  <= 1'b0;
            right_point_q <= 1'b0;
            point_right_q <= 1'b0;
        end else begin
            left_point_q  <= 1'b0;
            right_point_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    x_q <= IX_C;
                    y_q <= IY_C;
                    if (in_start) begin
                        cnt_q   <= CNT0_C;
                        speed_q <= SPD0_C;
                        state_q <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (tick) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q <= CNT_W'(1)) begin
                            state_q <= ST_PLAY;
                        end
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (miss) begin
                            point_right_q <= (x_dir_q == DIR_LEFT);
                            state_q       <= ST_POINT;
                        end else begin
                            x_q      <= x_d;
                            y_q      <= y_d;
                            x_dir_q  <= x_dir_d;
                            y_dir_q  <= y_dir_d;
                            y_move_q <= y_move_d;
                            speed_q  <= speed_d;
                        end
                    end
                end
                ST_POINT: begin
                    // Score and pulse land on exit, so a reset here leaves no trace.
                    if (point_right_q) begin
                        right_score_q <= score_d;
                        right_point_q <= 1'b1;
                    end else begin
                        left_score_q <= score_d;
                        left_point_q <= 1'b1;
                    end
                    x_q <= IX_C;
                    y_q <= IY_C;
                    if (won) begin
                        state_q <= ST_OVER;
                    end else begin
                        cnt_q    <= CNT0_C;
                        speed_q  <= SPD0_C;
                        x_dir_q  <= point_right_q ? DIR_LEFT : DIR_RIGHT;
                        y_dir_q  <= lfsr_bit;
                        y_move_q <= 1'b1;
                        state_q  <= ST_SERVE;
                    end
                end
                ST_OVER: begin
                    x_q <= IX_C;
                    y_q <= IY_C;
                    if (in_start) begin
                        left_score_q  <= '0;
                        right_score_q <= '0;
                        cnt_q         <= CNT0_C;
                        speed_q       <= SPD0_C;
                        state_q       <= ST_SERVE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_left_score  = left_score_q;
    assign out_right_score = right_score_q;
    assign out_left_point  = left_point_q;
    assign out_right_point = right_point_q;
    assign out_speed       = speed_q;
    assign out_state       = state_q;
    assign out_game_over   = (state_q == ST_OVER);

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: directed game scenarios plus a randomized run against a rule-level model.
module tb_ball_engine;
    import ball_engine_pkg::*;

    localparam int IX = 320, IY = 240, HS = 10, VS = 10, BW = 20, BL = 180;
    localparam int DW = 639, DH = 470, TM = 5, SP0 = 2, SPM = 6, STK = 60, WIN = 5;
    localparam int FAR = 4000;

    logic        in_clock = 1'b0;
    logic        in_reset = 1'b1;
    logic        in_ani_stb = 1'b0;
    logic        in_animate = 1'b0;
    logic        in_start = 1'b0;
    logic [11:0] in_leftbar_top = '0;
    logic [11:0] in_rightbar_top = '0;
    logic [11:0] out_x1, out_x2, out_y1, out_y2;
    logic [3:0]  out_left_score, out_right_score;
    logic        out_left_point, out_right_point;
    logic [3:0]  out_speed;
    logic [2:0]  out_state;
    logic        out_game_over;

    int checks = 0;
    int failures = 0;

    // Reference model: plain integers, directions as +1/-1.
    state_e mst;
    int mx, my, mxd, myd, mym, msp, mcnt, mls, mrs, mlp, mrp, mpr, mlfsr;
    int ltop_v = 0, rtop_v = 0;

    ball_engine dut (
        .in_clock        (in_clock),
        .in_reset        (in_reset),
        .in_ani_stb      (in_ani_stb),
        .in_animate      (in_animate),
        .in_start        (in_start),
        .in_leftbar_top  (in_leftbar_top),
        .in_rightbar_top (in_rightbar_top),
        .out_x1          (out_x1),
        .out_x2          (out_x2),
        .out_y1          (out_y1),
        .out_y2          (out_y2),
        .out_left_score  (out_left_score),
        .out_right_score (out_right_score),
        .out_left_point  (out_left_point),
        .out_right_point (out_right_point),
        .out_speed       (out_speed),
        .out_state       (out_state),
        .out_game_over   (out_game_over)
    );

    always #5 in_clock = ~in_clock;

    function automatic int track(input int y, input int off);
        return (y > off) ? y - off : 0;
    endfunction

    task automatic model_serve();
        mx = IX; my = IY; mcnt = STK; msp = SP0;
    endtask

    task automatic model_step(input bit rst, input bit start, input bit tk);
        int lf_now, x1, x2, y1, y2, top, nxd, ndy, nym, nsp, sc;
        bit chk, onbar;
        if (rst) begin
            mst = ST_IDLE; mx = IX; my = IY; mxd = 1; myd = 1; mym = 1; msp = SP0;
            mcnt = 0; mls = 0; mrs = 0; mlp = 0; mrp = 0; mpr = 0; mlfsr = 1;
            return;
        end
        lf_now = mlfsr;
        mlfsr = ((mlfsr << 1) & 15) | (((mlfsr >> 3) ^ (mlfsr >> 2)) & 1);
        mlp = 0; mrp = 0;
        case (mst)
            ST_IDLE: begin
                mx = IX; my = IY;
                if (start) begin model_serve(); mst = ST_SERVE; end
            end
            ST_SERVE: begin
                if (tk) begin
                    mcnt = mcnt - 1;
                    if (mcnt == 0) mst = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tk) begin
                    x1 = (mx - HS) & 4095; x2 = (mx + HS) & 4095;
                    y1 = (my - VS) & 4095; y2 = (my + VS) & 4095;
                    chk = 0; top = 0;
                    if (mxd < 0 && x1 <= BW) begin chk = 1; top = ltop_v; end
                    else if (mxd > 0 && x2 >= DW - BW) begin chk = 1; top = rtop_v; end
                    onbar = (y2 >= top) && (y1 <= top + BL);
                    if (chk && !onbar) begin
                        mpr = (mxd < 0) ? 1 : 0;
                        mst = ST_POINT;
                    end else begin
                        nxd = mxd; ndy = myd; nym = mym; nsp = msp;
                        if (mym != 0) begin
                            if (myd < 0 && y1 <= TM) ndy = 1;
                            else if (myd > 0 && y2 >= DH) ndy = -1;
                        end
                        if (chk) begin
                            nxd = -mxd;
                            nsp = (msp + 1 > SPM) ? SPM : msp + 1;
                            if (my < top + BL / 3) begin ndy = -1; nym = 1; end
                            else if (my > top + 2 * BL / 3) begin ndy = 1; nym = 1; end
                            else nym = 0;
                        end
                        mx = (mx + nxd * nsp) & 4095;
                        if (nym != 0) my = (my + ndy * nsp) & 4095;
                        mxd = nxd; myd = ndy; mym = nym; msp = nsp;
                    end
                end
            end
            ST_POINT: begin
                if (mpr != 0) begin
                    mrs = (mrs < 15) ? mrs + 1 : 15; mrp = 1; sc = mrs;
                end else begin
                    mls = (mls < 15) ? mls + 1 : 15; mlp = 1; sc = mls;
                end
                mx = IX; my = IY;
                if (sc >= WIN) begin
                    mst = ST_OVER;
                end else begin
                    model_serve();
                    mxd = (mpr != 0) ? -1 : 1;
                    myd = ((lf_now & 1) != 0) ? 1 : -1;
                    mym = 1;
                    mst = ST_SERVE;
                end
            end
            default: begin
                mx = IX; my = IY;
                if (start) begin mls = 0; mrs = 0; model_serve(); mst = ST_SERVE; end
            end
        endcase
    endtask

    task automatic cycle(input bit rst, input bit start, input bit stb, input bit anim);
        in_reset = rst; in_start = start; in_ani_stb = stb; in_animate = anim;
        in_leftbar_top = 12'(ltop_v); in_rightbar_top = 12'(rtop_v);
        @(posedge in_clock);
        model_step(rst, start, stb && anim);
        #1;
    endtask

    task automatic tick();
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (out_state !== 3'(ST_IDLE)) begin failures++; $display("FAIL reset_state got %0d want %0d", out_state, ST_IDLE); end
        checks++; if (out_x1 !== 12'd310 || out_x2 !== 12'd330) begin failures++; $display("FAIL reset_x got %0d/%0d want 310/330", out_x1, out_x2); end
        checks++; if (out_y1 !== 12'd230 || out_y2 !== 12'd250) begin failures++; $display("FAIL reset_y got %0d/%0d want 230/250", out_y1, out_y2); end
        checks++; if (out_speed !== 4'd2) begin failures++; $display("FAIL reset_speed got %0d want 2", out_speed); end
        checks++; if (out_left_score !== 4'd0 || out_right_score !== 4'd0 || out_left_point !== 1'b0 || out_right_point !== 1'b0 || out_game_over !== 1'b0) begin
            failures++; $display("FAIL reset_score got %0d/%0d/%0d/%0d/%0d want 0", out_left_score, out_right_score, out_left_point, out_right_point, out_game_over);
        end
    endtask

    task automatic test_serve();
        int bad = 0;
        ltop_v = FAR; rtop_v = FAR;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (out_state !== 3'(ST_SERVE)) begin failures++; $display("FAIL start_no_tick got %0d want %0d", out_state, ST_SERVE); end
        for (int i = 0; i < 6; i++) cycle(1'b0, i[0], 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= STK; i++) begin
            tick();
            if (i < STK && out_state !== 3'(ST_SERVE)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL serve_length got %0d early exits want 0", bad); end
        checks++; if (out_state !== 3'(ST_PLAY) || out_x1 !== 12'd310) begin failures++; $display("FAIL serve_end got state %0d x1 %0d want %0d 310", out_state, out_x1, ST_PLAY); end
        tick();
        checks++; if (out_x1 !== 12'd312) begin failures++; $display("FAIL first_move got x1 %0d want 312", out_x1); end
    endtask

    task automatic test_middle_hit();
        bit found = 0;
        int saved;
        ltop_v = FAR;
        for (int i = 0; i < 600; i++) begin
            rtop_v = track(my, 90);
            tick();
            if (mxd < 0) begin found = 1; break; end
        end
        checks++; if (!found) begin failures++; $display("FAIL middle_hit got no hit want hit"); end
        checks++; if (out_speed !== 4'd3) begin failures++; $display("FAIL middle_speed got %0d want 3", out_speed); end
        saved = my;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (out_y1 !== 12'(saved - VS)) begin failures++; $display("FAIL middle_y_const got %0d want %0d", out_y1, saved - VS); end
        end
    endtask

    task automatic test_point();
        bit found = 0;
        int pulses = 0;
        ltop_v = FAR;
        for (int i = 0; i < 600; i++) begin
            rtop_v = track(my, 90);
            tick();
            if (mst == ST_POINT) begin found = 1; break; end
        end
        checks++; if (!found || out_state !== 3'(ST_POINT)) begin failures++; $display("FAIL left_miss got state %0d want %0d", out_state, ST_POINT); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_right_point === 1'b1) pulses++;
            checks++; if (out_left_point !== 1'b0) begin failures++; $display("FAIL wrong_pulse got 1 want 0"); end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL point_pulse got %0d cycles want 1", pulses); end
        checks++; if (out_right_score !== 4'd1 || out_left_score !== 4'd0) begin failures++; $display("FAIL point_score got %0d/%0d want 0/1", out_left_score, out_right_score); end
    endtask

    task automatic test_top_hit();
        bit found = 0;
        int y_old;
        ltop_v = FAR;
        for (int i = 0; i < 600; i++) begin
            if (mst == ST_PLAY && mx == 30 && mxd < 0) begin found = 1; break; end
            tick();
        end
        checks++; if (!found || out_x1 !== 12'd20 || out_speed !== 4'd2) begin failures++; $display("FAIL reach_left got x1 %0d speed %0d want 20 2", out_x1, out_speed); end
        y_old = my;
        ltop_v = y_old - 10;
        tick();
        checks++; if (out_x1 !== 12'd23) begin failures++; $display("FAIL top_hit_x got %0d want 23", out_x1); end
        checks++; if (out_speed !== 4'd3) begin failures++; $display("FAIL top_hit_speed got %0d want 3", out_speed); end
        checks++; if (out_y1 !== 12'(y_old - 3 - VS)) begin failures++; $display("FAIL top_hit_y got %0d want %0d", out_y1, 12'(y_old - 3 - VS)); end
    endtask

    task automatic test_game_over();
        bit found = 0;
        ltop_v = FAR;
        for (int i = 0; i < 6000; i++) begin
            rtop_v = track(my, 90);
            tick();
            checks++; if (out_right_point !== 1'(mrp)) begin failures++; $display("FAIL rally_pulse got %0d want %0d", out_right_point, mrp); end
            if (mst == ST_OVER) begin found = 1; break; end
        end
        checks++; if (!found || out_game_over !== 1'b1) begin failures++; $display("FAIL game_over got %0d want 1", out_game_over); end
        checks++; if (out_right_score !== 4'd5 || out_left_score !== 4'd0) begin failures++; $display("FAIL final_score got %0d/%0d want 0/5", out_left_score, out_right_score); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (out_x1 !== 12'd310 || out_y1 !== 12'd230 || out_right_score !== 4'd5) begin failures++; $display("FAIL over_hold got %0d/%0d/%0d want 310/230/5", out_x1, out_y1, out_right_score); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (out_state !== 3'(ST_SERVE) || out_right_score !== 4'd0 || out_game_over !== 1'b0) begin failures++; $display("FAIL restart got state %0d score %0d want %0d 0", out_state, out_right_score, ST_SERVE); end
    endtask

    task automatic test_reset_in_point();
        bit found = 0;
        ltop_v = FAR; rtop_v = FAR;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            tick();
            if (mst == ST_POINT) begin found = 1; break; end
        end
        checks++; if (!found) begin failures++; $display("FAIL reach_point got none want POINT"); end
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_left_point !== 1'b0 || out_left_score !== 4'd0 || out_state !== 3'(ST_IDLE)) begin
            failures++; $display("FAIL reset_point got pulse %0d score %0d state %0d want 0 0 %0d", out_left_point, out_left_score, out_state, ST_IDLE);
        end
    endtask

    task automatic test_speed_saturation();
        int hits = 0, prev_dir, max_seen = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4000 && hits < 8; i++) begin
            ltop_v = track(my, 90); rtop_v = track(my, 90);
            prev_dir = mxd;
            tick();
            if (mxd != prev_dir) hits++;
            if (int'(out_speed) > max_seen) max_seen = int'(out_speed);
        end
        checks++; if (hits != 8) begin failures++; $display("FAIL hit_count got %0d want 8", hits); end
        checks++; if (out_speed !== 4'd6 || max_seen != SPM) begin failures++; $display("FAIL speed_sat got %0d max %0d want 6", out_speed, max_seen); end
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (out_state !== 3'(ST_IDLE) || out_x1 !== 12'd310) begin failures++; $display("FAIL reset_dominates got state %0d x1 %0d want %0d 310", out_state, out_x1, ST_IDLE); end
    endtask

    task automatic test_random();
        int lf = 0;
        for (int i = 0; i < 5000; i++) begin
            ltop_v = track(my, $urandom_range(0, 260));
            rtop_v = track(my, $urandom_range(0, 260));
            cycle($urandom_range(0, 499) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
            lf = failures;
            checks++; if (out_x1 !== 12'((mx - HS) & 4095) || out_x2 !== 12'((mx + HS) & 4095)) failures++;
            checks++; if (out_y1 !== 12'((my - VS) & 4095) || out_y2 !== 12'((my + VS) & 4095)) failures++;
            checks++; if (out_state !== 3'(mst) || out_game_over !== (mst == ST_OVER)) failures++;
            checks++; if (out_left_score !== 4'(mls) || out_right_score !== 4'(mrs)) failures++;
            checks++; if (out_left_point !== 1'(mlp) || out_right_point !== 1'(mrp)) failures++;
            checks++; if (out_speed !== 4'(msp)) failures++;
            if (failures != lf && failures < 40) begin
                $display("FAIL random cycle %0d got x1=%0d y1=%0d st=%0d sc=%0d/%0d pt=%0d/%0d spd=%0d want x1=%0d y1=%0d st=%0d sc=%0d/%0d pt=%0d/%0d spd=%0d",
                         i, out_x1, out_y1, out_state, out_left_score, out_right_score, out_left_point, out_right_point, out_speed,
                         (mx - HS) & 4095, (my - VS) & 4095, mst, mls, mrs, mlp, mrp, msp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_middle_hit();
        test_point();
        test_top_hit();
        test_game_over();
        test_reset_in_point();
        test_speed_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 SHALL have parameter COORD_W, default 12, meaning width of all coordinate ports and registers.
REQ-002 SHALL have parameters H_SIZE=10 and V_SIZE=10, meaning half ball width and half ball height.
REQ-003 SHALL have parameters IX=320 and IY=240, meaning the serve position of the ball centre.
REQ-004 SHALL have parameters BAR_WIDTH=20 and BAR_LENGTH=180, meaning paddle width and paddle length.
REQ-005 SHALL have parameters D_WIDTH=639, D_HEIGHT=470 and TOP_MARGIN=5, meaning the playfield limits.
REQ-006 SHALL have parameters SPEED_INIT=2 and SPEED_MAX=6, meaning serve speed and speed ceiling, in pixels per tick.
REQ-007 SHALL have parameters SERVE_TICKS=60, SCORE_W=4 and WIN_SCORE=5, meaning serve delay in ticks, score width and winning score.
REQ-008 Ports, one per line, name / direction / width / meaning:
- in_clock, in, 1, sole clock, posedge.
- in_reset, in, 1, synchronous active-high reset.
- in_ani_stb, in, 1, animation strobe.
- in_animate, in, 1, animation enable.
- in_start, in, 1, start request, sampled every cycle.
- in_leftbar_top, in, COORD_W, top edge of the left paddle.
- in_rightbar_top, in, COORD_W, top edge of the right paddle.
- out_x1, out_x2, out_y1, out_y2, out, COORD_W each, ball left/right/top/bottom edges.
- out_left_score, out_right_score, out, SCORE_W each, scores.
- out_left_point, out_right_point, out, 1 each, one-cycle point pulses.
- out_speed, out, 4, current speed.
- out_state, out, 3, FSM state encoding.
- out_game_over, out, 1, high while in OVER.

Function
REQ-009 A tick SHALL be a cycle with in_ani_stb=1 and in_animate=1; motion and the serve countdown advance only on ticks.
REQ-010 The edge outputs SHALL be combinational from the centre registers: x-H_SIZE, x+H_SIZE, y-V_SIZE, y+V_SIZE.
REQ-011 The FSM SHALL have the states IDLE, SERVE, PLAY, POINT and OVER.
REQ-012 In IDLE: ball held at (IX, IY); in_start=1 moves to SERVE on the next cycle, with or without a tick.
REQ-013 On entry to SERVE: ball at (IX, IY), countdown loaded with SERVE_TICKS, speed set to SPEED_INIT.
REQ-014 In SERVE: each tick decrements the countdown; the tick on which it reaches 0 moves to PLAY.
REQ-015 In PLAY, each tick SHALL evaluate collisions on the current registers, update direction and speed, then move by the updated speed in the updated direction, all in that same cycle.
REQ-016 Left paddle check SHALL apply when x_dir=left and out_x1 <= BAR_WIDTH.
- Hit condition: out_y2 >= in_leftbar_top and out_y1 <= in_leftbar_top+BAR_LENGTH.
- Otherwise the tick is a miss.
REQ-017 Right paddle check SHALL apply when x_dir=right and out_x2 >= D_WIDTH-BAR_WIDTH, using the same rule with in_rightbar_top.
REQ-018 On a hit:
- x_dir reverses.
- Speed becomes min(speed+1, SPEED_MAX).
- y motion follows the paddle zone by ball centre y: top third sets y_dir=up, bottom third sets y_dir=down, middle third sets vertical motion to 0.
- Zone boundaries are bar_top+BAR_LENGTH/3 and bar_top+2*BAR_LENGTH/3; a centre equal to a boundary counts as middle.
REQ-019 On a miss: no move that tick; go to POINT, crediting right on a left miss and left on a right miss.
REQ-020 Wall bounce SHALL apply only while vertical motion is nonzero.
- out_y1 <= TOP_MARGIN while moving up sets y_dir=down.
- out_y2 >= D_HEIGHT while moving down sets y_dir=up.
REQ-021 A wall bounce and a paddle hit on the same tick SHALL both apply; the paddle zone rule has priority for y_dir.
REQ-022 POINT SHALL last exactly 1 cycle.
- Pulses the scorer's point output.
- Increments the scorer's score, saturating at 2^SCORE_W-1.
- Goes to OVER if the new score >= WIN_SCORE, otherwise to SERVE.
REQ-023 The serve after a point SHALL set x_dir toward the side that conceded; y_dir comes from LFSR bit 0 and vertical motion is enabled.
REQ-024 In OVER: ball held at centre and scores frozen; in_start clears both scores and goes to SERVE.
REQ-025 in_start SHALL be ignored in SERVE, PLAY and POINT.
REQ-026 in_animate=0 SHALL freeze motion and the countdown but not FSM handshakes.

Reset
REQ-027 in_reset SHALL dominate all other inputs in the same cycle.
REQ-028 Reset values: state IDLE, x=IX, y=IY, x_dir=right, y_dir=down, speed=SPEED_INIT, scores 0, pulses 0, countdown 0.
REQ-029 Reset asserted mid-PLAY or in POINT SHALL discard any pending point, with no pulse emitted.

Structure
REQ-030 A shared package SHALL hold the state enumeration and the direction constants (LEFT/RIGHT, UP/DOWN).
REQ-031 Exactly one sub-module SHALL be instantiated: LFSR (NUM_BITS=4, always enabled) for serve randomness.

Verification
REQ-032 Reset, then in_start, then 60 ticks: SERVE lasts 60 ticks; on tick 61 x=322 (right serve at speed 2).
REQ-033 Ball moving left at speed 2 with x=30, leftbar_top=150, y=160: next tick x_dir=right, speed=3, y_dir=up, x=33.
REQ-034 Same setup with y=240 (middle third): y constant over the following 10 ticks.
REQ-035 Ball moving left with x=30, leftbar_top=300, y=100: out_right_point pulses for exactly 1 cycle and right score goes 0->1.
REQ-036 Right score at 4, then another right point: out_game_over=1 and further ticks leave the ball at (320,240); in_start gives scores 0 and state SERVE.
REQ-037 Eight consecutive paddle hits: out_speed saturates at 6; in_reset and in_start in the same cycle give state IDLE.
